// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: default geometry and handshake state codes.
package irq_ctrl_pkg;

    localparam int unsigned DEF_NUM_IRQ = 6;
    localparam int unsigned DEF_VEC_W   = 3;

    // Timer occupies the source slot just above the external lines.
    localparam int unsigned IRQ_TIMER_IDX = DEF_NUM_IRQ;

    localparam logic [1:0] IRQ_ST_IDLE    = 2'd0;
    localparam logic [1:0] IRQ_ST_REQ     = 2'd1;
    localparam logic [1:0] IRQ_ST_SERVICE = 2'd2;

endpackage

// File: rtl/irq_timer.sv
// Count/Compare timer: free-running count, writable compare, sticky match flag.
module irq_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_wr,
    input  logic        cmp_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;

    always_comb begin
        count_d   = cnt_wr ? wr_data : count_q + 32'd1;
        compare_d = cmp_wr ? wr_data : compare_q;
        // Match on the value currently held; a Compare write clears even on a match cycle.
        pend_d    = cmp_wr ? 1'b0 : (pend_q | (count_q == compare_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count      = count_q;
    assign compare    = compare_q;
    assign timer_pend = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt source side of CP0: samples lines, masks and prioritises them, and runs the
// req/ack/eret handshake towards the coprocessor.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = DEF_NUM_IRQ,
    parameter int unsigned VEC_W   = DEF_VEC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ:0]   irq_mask,
    input  logic               ie,
    input  logic               exl,
    input  logic               cnt_wr,
    input  logic               cmp_wr,
    input  logic [31:0]        wr_data,
    input  logic               ack,
    input  logic               eret,
    output logic [31:0]        count,
    output logic [31:0]        compare,
    output logic [NUM_IRQ:0]   pending,
    output logic               req,
    output logic [VEC_W-1:0]   req_vec
);

    logic               timer_pend;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ:0]   eligible;
    logic [VEC_W-1:0]   winner;
    logic [1:0]         state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    irq_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_wr     (cnt_wr),
        .cmp_wr     (cmp_wr),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
        end
    end

    assign pending  = {timer_pend, irq_q};
    assign eligible = pending & irq_mask;

    // Later (higher) indices overwrite earlier ones, so the highest set source wins.
    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i <= NUM_IRQ; i++) begin
            if (eligible[i]) begin
                winner = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            IRQ_ST_IDLE: begin
                if (ie && !exl && (|eligible)) begin
                    state_d = IRQ_ST_REQ;
                    vec_d   = winner;
                end
            end
            IRQ_ST_REQ: begin
                // ack takes priority over a concurrent global-disable withdrawal.
                if (ack) begin
                    state_d = IRQ_ST_SERVICE;
                end else if (!ie) begin
                    state_d = IRQ_ST_IDLE;
                end
            end
            IRQ_ST_SERVICE: begin
                if (eret) begin
                    state_d = IRQ_ST_IDLE;
                end
            end
            default: state_d = IRQ_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_ST_IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    // Decoded straight from state so an async reset drops the request immediately.
    assign req     = (state_q == IRQ_ST_REQ);
    assign req_vec = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a behavioural model checked every cycle plus literal pins.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  irq_in;
    logic [6:0]  irq_mask;
    logic        ie, exl, cnt_wr, cmp_wr, ack, eret;
    logic [31:0] wr_data;
    logic [31:0] count, compare;
    logic [6:0]  pending;
    logic        req;
    logic [2:0]  req_vec;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.NUM_IRQ(6), .VEC_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .ie       (ie),
        .exl      (exl),
        .cnt_wr   (cnt_wr),
        .cmp_wr   (cmp_wr),
        .wr_data  (wr_data),
        .ack      (ack),
        .eret     (eret),
        .count    (count),
        .compare  (compare),
        .pending  (pending),
        .req      (req),
        .req_vec  (req_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is either outstanding (m_req), being serviced (m_busy) or neither.
    logic [31:0] m_count, m_compare;
    logic        m_tpend;
    logic [5:0]  m_irq;
    logic        m_req, m_busy;
    logic [2:0]  m_vec;

    function automatic logic [2:0] top_source(input logic [6:0] v);
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count   <= 32'd0;
            m_compare <= 32'hFFFF_FFFF;
            m_tpend   <= 1'b0;
            m_irq     <= 6'd0;
            m_req     <= 1'b0;
            m_busy    <= 1'b0;
            m_vec     <= 3'd0;
        end else begin
            m_count   <= cnt_wr ? wr_data : m_count + 32'd1;
            m_compare <= cmp_wr ? wr_data : m_compare;
            m_tpend   <= !cmp_wr && (m_tpend || m_count == m_compare);
            m_irq     <= irq_in;
            if (m_req) begin
                if (ack) begin
                    m_req  <= 1'b0;
                    m_busy <= 1'b1;
                end else if (!ie) begin
                    m_req <= 1'b0;
                end
            end else if (m_busy) begin
                if (eret) m_busy <= 1'b0;
            end else if (ie && !exl && (({m_tpend, m_irq} & irq_mask) != 7'd0)) begin
                m_req <= 1'b1;
                m_vec <= top_source({m_tpend, m_irq} & irq_mask);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_count", count, m_count);
            check("model_compare", compare, m_compare);
            check("model_pending", {25'd0, pending}, {25'd0, m_tpend, m_irq});
            check("model_req", {31'd0, req}, {31'd0, m_req});
            if (m_req) check("model_req_vec", {29'd0, req_vec}, {29'd0, m_vec});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; irq_mask = '0; ie = 0; exl = 0;
        cnt_wr = 0; cmp_wr = 0; ack = 0; eret = 0; wr_data = '0;
        repeat (2) tick();

        // 1: reset values and free-running count
        rst_n = 1'b1;
        check("rst_count0", count, 32'd0);
        check("rst_compare", compare, 32'hFFFF_FFFF);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_vec", {29'd0, req_vec}, 32'd0);
        tick(); check("rst_count1", count, 32'd1);
        tick(); check("rst_count2", count, 32'd2);

        // 2: single source, two-edge latency, ack, eret, re-request
        ie = 1; irq_mask = 7'h7F; irq_in = 6'b000100;
        tick(); check("lat_req_low", {31'd0, req}, 32'd0);
        tick(); check("irq2_req", {31'd0, req}, 32'd1);
        check("irq2_vec", {29'd0, req_vec}, 32'd2);
        ack = 1; tick(); ack = 0;
        check("ack_req_low", {31'd0, req}, 32'd0);
        tick(); check("service_no_req", {31'd0, req}, 32'd0);
        eret = 1; tick(); eret = 0;
        check("eret_edge_req_low", {31'd0, req}, 32'd0);
        tick(); check("rereq", {31'd0, req}, 32'd1);
        check("rereq_vec", {29'd0, req_vec}, 32'd2);
        ack = 1; tick(); ack = 0; irq_in = '0;
        eret = 1; tick(); eret = 0;
        tick(); check("idle_quiet", {31'd0, req}, 32'd0);

        // 3: priority and frozen vector
        irq_in = 6'b010010;
        tick(); tick();
        check("prio_vec", {29'd0, req_vec}, 32'd4);
        irq_in = 6'b000010;
        tick(); check("frozen_req", {31'd0, req}, 32'd1);
        tick(); check("frozen_vec", {29'd0, req_vec}, 32'd4);
        ack = 1; tick(); ack = 0; irq_in = '0;
        eret = 1; tick(); eret = 0; tick();

        // 4: timer match and clear
        cnt_wr = 1; wr_data = 32'h10; tick();
        cnt_wr = 0; cmp_wr = 1; wr_data = 32'h14; tick();
        cmp_wr = 0;
        check("tmr_count", count, 32'h11);
        check("tmr_compare", compare, 32'h14);
        begin : wait_timer
            for (int i = 0; i < 20; i++) begin
                if (req) disable wait_timer;
                tick();
            end
        end
        check("tmr_req", {31'd0, req}, 32'd1);
        check("tmr_vec", {29'd0, req_vec}, 32'd6);
        check("tmr_req_count", count, 32'h16);
        ack = 1; tick(); ack = 0;
        cmp_wr = 1; wr_data = 32'h8000_0000; tick(); cmp_wr = 0;
        check("tmr_clear", {31'd0, pending[6]}, 32'd0);
        eret = 1; tick(); eret = 0;

        // 4b: wrap through zero with compare=0
        ie = 0;
        cmp_wr = 1; wr_data = 32'h0; tick(); cmp_wr = 0;
        cnt_wr = 1; wr_data = 32'hFFFF_FFFD; tick(); cnt_wr = 0;
        check("wrap_load", count, 32'hFFFF_FFFD);
        begin : wait_wrap
            for (int i = 0; i < 10; i++) begin
                if (pending[6]) disable wait_wrap;
                tick();
            end
        end
        check("wrap_pend", {31'd0, pending[6]}, 32'd1);
        check("wrap_count", count, 32'd1);
        cmp_wr = 1; wr_data = 32'h8000_0000; tick(); cmp_wr = 0;
        check("wrap_clear", {31'd0, pending[6]}, 32'd0);

        // 5: withdrawal by ie=0, and ack winning over ie=0
        irq_in = 6'b001000; ie = 1;
        tick(); tick();
        check("wd_req", {31'd0, req}, 32'd1);
        check("wd_vec", {29'd0, req_vec}, 32'd3);
        ie = 0; tick();
        check("wd_req_low", {31'd0, req}, 32'd0);
        ie = 1; tick();
        check("wd_rereq", {31'd0, req}, 32'd1);
        ack = 1; ie = 0; tick(); ack = 0;
        check("ackwin_req_low", {31'd0, req}, 32'd0);
        ie = 1; tick(); tick();
        check("ackwin_service", {31'd0, req}, 32'd0);
        eret = 1; tick(); eret = 0;
        tick(); check("ackwin_rereq", {31'd0, req}, 32'd1);
        ack = 1; tick(); ack = 0; irq_in = '0;
        eret = 1; tick(); eret = 0; tick();

        // 6: exl and mask block, then async reset mid-request
        irq_in = 6'b000001; exl = 1;
        tick(); tick(); tick();
        check("exl_block", {31'd0, req}, 32'd0);
        exl = 0; irq_mask = 7'h7E;
        tick(); tick();
        check("mask_block", {31'd0, req}, 32'd0);
        irq_mask = 7'h7F; tick();
        check("unmask_req", {31'd0, req}, 32'd1);
        check("unmask_vec", {29'd0, req_vec}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, req}, 32'd0);
        check("async_count", count, 32'd0);
        check("async_compare", compare, 32'hFFFF_FFFF);
        tick(); rst_n = 1'b1;
        irq_in = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
